// File: rtl/student_inc16_pkg.sv
// ----------------------------------------------------------------------------
// student_inc16_pkg
// Purpose : shared constants and types for the 16-bit ripple-carry adder block.
// Contents:
//   INC16_WIDTH     - default operand/result width of the adder
//   inc16_result_t  - packed {carry, sum} pair, handy for consumers that want
//                     the adder result as one bundle
// ----------------------------------------------------------------------------
package student_inc16_pkg;

  // Only the 16-bit configuration is exercised; other widths elaborate but are
  // not checked.
  localparam int INC16_WIDTH = 16;

  typedef struct packed {
    logic                   carry;
    logic [INC16_WIDTH-1:0] sum;
  } inc16_result_t;

endpackage

// File: rtl/student_inc16_full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// Purpose : one-bit full adder built from two half adders (XOR/AND gates) and
//           an OR that merges their carries. Used as the cell of the ripple
//           chain in student_inc16.
// Ports   :
//   a, b  in  1  operand bits
//   cin   in  1  carry from the next-lower bit
//   sum   out 1  a ^ b ^ cin
//   cout  out 1  carry into the next-higher bit
// ----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  // First half adder combines the two operand bits.
  assign ha0_sum   = a ^ b;
  assign ha0_carry = a & b;

  // Second half adder folds in the incoming carry.
  assign sum       = ha0_sum ^ cin;
  assign ha1_carry = ha0_sum & cin;

  // At most one half adder can generate a carry, so OR is sufficient.
  assign cout      = ha0_carry | ha1_carry;

endmodule

// File: rtl/student_inc16.sv
// ----------------------------------------------------------------------------
// student_inc16
// Purpose : WIDTH-bit adder for the Hack ALU family. Produces a combinational
//           sum/carry with zero latency and a registered copy for pipelined
//           consumers. Addition wraps modulo 2^WIDTH; signed and unsigned
//           operands share the same bit pattern, so no overflow flag exists.
// Ports   :
//   clk      in   1      rising-edge clock, used only by the registered outputs
//   rst      in   1      asynchronous active-high reset of the registered outputs
//   a        in   WIDTH  operand A
//   b        in   WIDTH  operand B
//   out      out  WIDTH  combinational a + b (low WIDTH bits)
//   carry    out  1      combinational carry-out of the top bit
//   out_q    out  WIDTH  out captured on each rising clk
//   carry_q  out  1      carry captured on each rising clk
// ----------------------------------------------------------------------------
module student_inc16
  import student_inc16_pkg::*;
#(
  parameter int WIDTH = INC16_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic [WIDTH-1:0] out_q,
  output logic             carry_q
);

  // carry_chain[i] is the carry into bit i; carry_chain[WIDTH] is the carry-out.
  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH-1:0] out_d;
  logic             carry_d;

  assign carry_chain[0] = 1'b0;

  // Explicit ripple chain: each cell consumes the carry of the cell below.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_chain[i]),
      .sum  (sum_bits[i]),
      .cout (carry_chain[i+1])
    );
  end

  assign out   = sum_bits;
  assign carry = carry_chain[WIDTH];

  // The registered copy always follows the combinational result; there is no
  // enable, so the next-state is simply the current sum and carry.
  always_comb begin
    out_d   = out;
    carry_d = carry;
  end

  // Reset clears only the registered copy; the combinational path above never
  // sees clk or rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_student_inc16.sv
// ----------------------------------------------------------------------------
// tb_student_inc16
// Purpose : directed self-checking bench for student_inc16. Drives operand
//           pairs with hand-computed results, checks the combinational outputs
//           shortly after each change, the registered outputs after the
//           following rising edge, and the asynchronous reset between edges.
// ----------------------------------------------------------------------------
module tb_student_inc16;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;
  logic        carry;
  logic [15:0] out_q;
  logic        carry_q;

  int compared;
  int mismatched;

  // Directed vectors: operands plus the hand-computed 17-bit {carry,sum}.
  logic [15:0] vec_a   [6] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234};
  logic [15:0] vec_b   [6] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h5555, 16'h0FF0, 16'h9876};
  logic [16:0] vec_exp [6] = '{17'h00000, 17'h0FFFF, 17'h1FFFE, 17'h0FFFF, 17'h04CB3, 17'h0AAAA};

  // Extra directed vectors that exercise long carry ripples and the top bit.
  logic [15:0] ext_a   [4] = '{16'h0001, 16'h8000, 16'h7FFF, 16'hFFFF};
  logic [15:0] ext_b   [4] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h0001};
  logic [16:0] ext_exp [4] = '{17'h10000, 17'h10000, 17'h08000, 17'h10000};

  student_inc16 dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .out     (out),
    .carry   (carry),
    .out_q   (out_q),
    .carry_q (carry_q)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [16:0] observed,
                             input logic [16:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%05h, expected 0x%05h", tag, observed, expected);
    end
  endtask

  // Drives a new operand pair just after a falling edge, checks the
  // combinational result, confirms the register still holds the previous
  // value, then checks the register after the next rising edge.
  task automatic applyStimulus(input string tag, input logic [15:0] va,
                               input logic [15:0] vb, input logic [16:0] exp_sum,
                               input logic [16:0] prev_q);
    @(negedge clk);
    a = va;
    b = vb;
    #1;
    checkOutput({tag, "_comb"}, {carry, out}, exp_sum);
    checkOutput({tag, "_hold"}, {carry_q, out_q}, prev_q);
    @(posedge clk);
    #1;
    checkOutput({tag, "_reg"}, {carry_q, out_q}, exp_sum);
  endtask

  // Main sequence: reset state, directed vectors, async reset, release.
  initial begin
    logic [16:0] prev;
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    a   = 16'h1111;
    b   = 16'h2222;

    #2;
    checkOutput("reset_q", {carry_q, out_q}, 17'h00000);
    checkOutput("reset_comb", {carry, out}, 17'h03333);
    @(posedge clk);
    #1;
    checkOutput("reset_held", {carry_q, out_q}, 17'h00000);
    @(negedge clk);
    rst = 1'b0;

    prev = 17'h00000;
    @(posedge clk);
    #1;
    checkOutput("first_capture", {carry_q, out_q}, 17'h03333);
    prev = 17'h03333;

    for (int i = 0; i < 6; i++) begin
      applyStimulus($sformatf("vec%0d", i), vec_a[i], vec_b[i], vec_exp[i], prev);
      prev = vec_exp[i];
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("ext%0d", i), ext_a[i], ext_b[i], ext_exp[i], prev);
      prev = ext_exp[i];
    end

    // Load a carrying result, then pulse reset between edges.
    applyStimulus("pre_rst", 16'hFFFF, 16'hFFFF, 17'h1FFFE, prev);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_q", {carry_q, out_q}, 17'h00000);
    checkOutput("async_rst_comb", {carry, out}, 17'h1FFFE);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_q", {carry_q, out_q}, 17'h00000);
    @(negedge clk);
    rst = 1'b0;
    a   = 16'h1234;
    b   = 16'h9876;
    #1;
    checkOutput("post_rst_still_zero", {carry_q, out_q}, 17'h00000);
    @(posedge clk);
    #1;
    checkOutput("post_rst_capture", {carry_q, out_q}, 17'h0AAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
